// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// response data width, default base address and a RAM address-width helper.
package data_memory_responder_pkg;

    // Width of a memory word and of the response data bus.
    localparam int RSP_DATA_W = 32;

    // Byte address of word 0 unless the instance overrides it.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    // Wait counter width; wait states range over 0..15.
    localparam int WAIT_CNT_W = 4;

    // Responder FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of address bits needed to index a RAM of the given depth
    // (never less than one so a single-word RAM still has a port).
    function automatic int ram_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_memory_responder_ram.sv
// Single-port synchronous RAM. A read happens on every enabled edge and the
// registered read data holds until the next enabled edge. When written, the
// read data shows the contents from before the write. Contents are not reset.
module data_memory_responder_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Enabled access: write the addressed word if requested and capture its old contents.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: accepts one load/store request at a time, waits
// WAIT_STATES cycles, then presents a response until the initiator takes it.
//
// Optional feature: define DATA_MEMORY_RESPONDER_ERROR_CHECK_EN to reject
// misaligned, below-base or out-of-range addresses with rsp_error_o=1 and no
// memory write. Without it, addr[1:0] is ignored, the word index wraps
// modulo MEMORY_DEPTH and rsp_error_o is always 0.
//
// Handshakes: a request transfers on a rising edge with req_valid_i=1 and
// req_ready_o=1 (ready is high only in IDLE and never during reset). A
// response transfers on a rising edge with rsp_valid_o=1 and rsp_ready_i=1;
// until then every rsp_* output holds its value. Request inputs are ignored
// outside IDLE, so no request can transfer in the response-handshake cycle.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 256,
    parameter int          WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    output logic [RSP_DATA_W-1:0] rsp_rdata_o,
    output logic                  rsp_error_o,
    input  logic                  rsp_ready_i,
    output logic [1:0]            dbg_state_o
);

    localparam int                    ADDR_W    = ram_addr_width(MEMORY_DEPTH);
    localparam logic [31:0]           DEPTH_W32 = 32'(MEMORY_DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    // Registered state
    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    error_q, error_d;

    // Request as seen by the address check and the RAM
    logic                    eff_write;
    logic [31:0]             eff_addr;
    logic [31:0]             eff_wdata;

    // Address decode
    logic [31:0]             byte_off;
    logic [31:0]             word_idx;
    logic [31:0]             ram_idx;
    logic                    addr_err;
    logic                    unused_addr_bits;

    // RAM interface
    logic                    enter_resp;
    logic                    ram_en;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_addr;
    logic [RSP_DATA_W-1:0]   ram_rdata;

    logic                    rsp_active;

    // In IDLE the live request feeds the decode so that a zero-wait request
    // reaches the RAM on its own accept edge; later the latched copy is used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            eff_write = req_write_i;
            eff_addr  = req_addr_i;
            eff_wdata = req_wdata_i;
        end else begin
            eff_write = write_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
        end
    end

    // Word index in 32-bit unsigned arithmetic, plus the optional range/alignment check.
    always_comb begin
        byte_off = eff_addr - BASE_ADDR;
        word_idx = {2'b00, byte_off[31:2]};
`ifdef DATA_MEMORY_RESPONDER_ERROR_CHECK_EN
        addr_err = (eff_addr[1:0] != 2'b00) || (eff_addr < BASE_ADDR) ||
                   (word_idx >= DEPTH_W32);
        ram_idx  = word_idx;
`else
        addr_err = 1'b0;
        ram_idx  = word_idx % DEPTH_W32;
`endif
    end

    assign ram_addr         = ram_idx[ADDR_W-1:0];
    assign unused_addr_bits = ^{byte_off[1:0], ram_idx};

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (enter_resp) begin
            error_d = addr_err;
        end
    end

    // State register; reset aborts any request in flight and drops a pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
        end
    end

    // The RAM is touched exactly once per request, on the edge entering RESP.
    assign ram_en = enter_resp & ~reset;
    assign ram_we = ram_en & eff_write & ~addr_err;

    data_memory_responder_ram #(
        .DEPTH  (MEMORY_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (RSP_DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (eff_wdata),
        .rdata (ram_rdata)
    );

    // Outputs are forced to their idle values while reset is high.
    assign rsp_active  = (state_q == ST_RESP) & ~reset;
    assign req_ready_o = (state_q == ST_IDLE) & ~reset;
    assign rsp_valid_o = rsp_active;
    assign rsp_error_o = rsp_active & error_q;
    assign rsp_rdata_o = (rsp_active & ~write_q & ~error_q) ? ram_rdata : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: a WAIT_STATES=2 instance for
// latency, stall, address and reset behaviour, plus a WAIT_STATES=0 instance
// for back-to-back throughput. Expected responses come from a reference
// memory model through a scoreboard queue.
module tb_data_memory_responder;
    import data_memory_responder_pkg::*;

    localparam int          WS    = 2;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 256;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // WAIT_STATES=2 instance
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready_o, rsp_valid_o, rsp_error_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  dbg_state;

    data_memory_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
        .rsp_ready_i(rsp_ready), .dbg_state_o(dbg_state)
    );

    // WAIT_STATES=0 instance
    logic        r0_req_valid = 1'b0, r0_req_write = 1'b0, r0_rsp_ready = 1'b0;
    logic [31:0] r0_req_addr = '0, r0_req_wdata = '0;
    logic        r0_req_ready_o, r0_rsp_valid_o, r0_rsp_error_o;
    logic [31:0] r0_rsp_rdata_o;
    logic [1:0]  r0_dbg_state;

    data_memory_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid_i(r0_req_valid), .req_write_i(r0_req_write), .req_addr_i(r0_req_addr),
        .req_wdata_i(r0_req_wdata), .req_ready_o(r0_req_ready_o),
        .rsp_valid_o(r0_rsp_valid_o), .rsp_rdata_o(r0_rsp_rdata_o), .rsp_error_o(r0_rsp_error_o),
        .rsp_ready_i(r0_rsp_ready), .dbg_state_o(r0_dbg_state)
    );

    // Scoreboard and reference model
    logic [31:0] exp_q[$];
    logic [31:0] exp_err_q[$];
    logic [31:0] model_mem [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % 32'(DEPTH));
    endfunction

    function automatic logic model_err(input logic [31:0] a);
`ifdef DATA_MEMORY_RESPONDER_ERROR_CHECK_EN
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= 32'(DEPTH));
`else
        return (a === 32'hxxxx_xxxx);
`endif
    endfunction

    // Issue one request to the WAIT_STATES=2 instance and check its response.
    // Must be called at a negedge; hold = cycles to keep rsp_ready low.
    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        int          n;
        int          lat;
        logic        e;
        logic [31:0] first_d;
        logic        first_e;
        e = model_err(addr);
        exp_q.push_back((wr || e) ? 32'h0 : model_mem[model_idx(addr)]);
        exp_err_q.push_back({31'b0, e});
        if (wr && !e) model_mem[model_idx(addr)] = wdata;

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        if (!req_ready_o) begin
            check("accept_timeout", 32'(req_ready_o), 32'h1);
            req_valid = 1'b0;
            void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
            return;
        end
        @(negedge clk);
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin
            check("ready_low_in_wait", 32'(req_ready_o), 32'h0);
            req_write = 1'($urandom); req_wdata = $urandom;
            req_addr  = BASE + 32'($urandom_range(0, 15) * 4);
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        if (!rsp_valid_o) begin
            check("rsp_timeout", 32'(rsp_valid_o), 32'h1);
            void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
            rsp_ready = 1'b0;
            return;
        end
        check("rsp_latency", 32'(lat), 32'(WS + 1));
        check("rsp_rdata", rsp_rdata_o, exp_q.pop_front());
        check("rsp_error", 32'(rsp_error_o), exp_err_q.pop_front());
        first_d = rsp_rdata_o;
        first_e = rsp_error_o;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_addr = $urandom;
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid_o), 32'h1);
            check("hold_rdata", rsp_rdata_o, first_d);
            check("hold_error", 32'(rsp_error_o), 32'(first_e));
            check("hold_ready_low", 32'(req_ready_o), 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("idle_after_hs", 32'(dbg_state), 32'(ST_IDLE));
        check("ready_after_hs", 32'(req_ready_o), 32'h1);
        check("valid_after_hs", 32'(rsp_valid_o), 32'h0);
        rsp_ready = 1'b0;
    endtask

    // Accept a request, then reset it in WAIT (in_resp=0) or in RESP (in_resp=1).
    task automatic abort_req(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic in_resp);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        if (in_resp) begin
            n = 0;
            while (!rsp_valid_o && n < 40) begin @(negedge clk); n++; end
            check("abort_in_resp", 32'(dbg_state), 32'(ST_RESP));
        end else begin
            check("abort_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_ready", 32'(req_ready_o), 32'h0);
        check("abort_valid", 32'(rsp_valid_o), 32'h0);
        check("abort_rdata", rsp_rdata_o, 32'h0);
        check("abort_error", 32'(rsp_error_o), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(req_ready_o), 32'h1);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          prev_acc;
        logic [31:0] wd [4];
        logic [31:0] r0_exp[$];

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_valid", 32'(rsp_valid_o), 32'h0);
        check("rst_rdata", rsp_rdata_o, 32'h0);
        check("rst_error", 32'(rsp_error_o), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready_o), 32'h1);

        // Initialise the first 16 words
        for (int i = 0; i < 16; i++) do_req(1'b1, BASE + 32'(i * 4), $urandom, 0);

        // Store then load with rsp_ready held high
        do_req(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 32'h1001_0004, 32'h0, 0);

        // Load stalled for 5 cycles
        do_req(1'b0, 32'h1001_0004, 32'h0, 5);

`ifdef DATA_MEMORY_RESPONDER_ERROR_CHECK_EN
        do_req(1'b1, 32'h1001_0002, 32'hAAAA_5555, 1);
        do_req(1'b1, 32'h1001_0400, 32'h5555_AAAA, 0);
        do_req(1'b0, 32'h1001_0000, 32'h0, 0);
        do_req(1'b0, 32'h1000_FFFC, 32'h0, 0);
        do_req(1'b0, 32'h1001_0007, 32'h0, 2);
`else
        do_req(1'b1, 32'h1001_0400, 32'h1234_5678, 0);
        do_req(1'b0, 32'h1001_0000, 32'h0, 0);
        do_req(1'b1, 32'h1001_0013, 32'h0BAD_F00D, 1);
        do_req(1'b0, 32'h1001_0010, 32'h0, 0);
`endif

        // Reset during WAIT drops the store; reset during RESP drops the load
        do_req(1'b1, 32'h1001_0008, 32'hCAFE_0001, 0);
        abort_req(1'b1, 32'h1001_0008, 32'hCAFE_0002, 1'b0);
        do_req(1'b0, 32'h1001_0008, 32'h0, 0);
        abort_req(1'b0, 32'h1001_0008, 32'h0, 1'b1);
        do_req(1'b0, 32'h1001_0008, 32'h0, 1);

        // Random traffic over the initialised words
        for (int i = 0; i < 20; i++)
            do_req(1'($urandom), BASE + 32'($urandom_range(0, 15) * 4), $urandom,
                   $urandom_range(0, 3));

        // Zero wait states: valid one cycle after accept, accepts every 2 cycles
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        r0_rsp_ready = 1'b1;
        prev_acc = -1;
        for (int i = 0; i < 8; i++) begin
            r0_req_valid = 1'b1;
            r0_req_write = (i < 4);
            r0_req_addr  = BASE + 32'((i % 4) * 4);
            r0_req_wdata = wd[i % 4];
            r0_exp.push_back((i < 4) ? 32'h0 : wd[i % 4]);
            n = 0;
            while (!r0_req_ready_o && n < 10) begin @(negedge clk); n++; end
            if (!r0_req_ready_o) begin
                check("ws0_accept_timeout", 32'(r0_req_ready_o), 32'h1);
                break;
            end
            if (prev_acc >= 0) check("ws0_spacing", 32'(cyc - prev_acc), 32'h2);
            prev_acc = cyc;
            @(negedge clk);
            check("ws0_valid", 32'(r0_rsp_valid_o), 32'h1);
            check("ws0_rdata", r0_rsp_rdata_o, r0_exp.pop_front());
            check("ws0_error", 32'(r0_rsp_error_o), 32'h0);
        end
        r0_req_valid = 1'b0;
        @(negedge clk);
        check("ws0_idle", 32'(r0_dbg_state), 32'(ST_IDLE));
        r0_rsp_ready = 1'b0;

        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter MEMORY_DEPTH, default 256, is the number of 32-bit words stored.
REQ-002 Parameter WAIT_STATES, default 2, is the number of extra cycles between request accept and response; the legal range is 0..15.
REQ-003 Parameter BASE_ADDR, default 32'h1001_0000, is the byte address of word 0.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req_valid_i, input, 1 bit: the initiator presents a request.
REQ-007 Port req_write_i, input, 1 bit: 1 = store word, 0 = load word.
REQ-008 Port req_addr_i, input, 32 bits: byte address.
REQ-009 Port req_wdata_i, input, 32 bits: store data.
REQ-010 Port req_ready_o, output, 1 bit: the responder accepts a request this cycle.
REQ-011 Port rsp_valid_o, output, 1 bit: a response is presented.
REQ-012 Port rsp_rdata_o, output, 32 bits: load data; 0 for stores and errors.
REQ-013 Port rsp_error_o, output, 1 bit: the request was rejected.
REQ-014 Port rsp_ready_i, input, 1 bit: the initiator consumes the response.

Function
REQ-015 The FSM shall have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready_o shall be 1 only in IDLE.
REQ-017 A request shall be accepted on a rising edge where req_valid_i=1 and req_ready_o=1; at that edge the responder latches write, address and wdata.
REQ-018 On accept, the FSM shall go IDLE->WAIT with the wait counter loaded to WAIT_STATES; when WAIT_STATES=0 it shall go IDLE->RESP directly.
REQ-019 In WAIT, the counter shall decrement by one each cycle; when it reaches 1, the FSM shall go WAIT->RESP.
REQ-020 rsp_valid_o shall rise exactly WAIT_STATES+1 cycles after the accept edge.
REQ-021 The word index shall be (addr - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
REQ-022 A store shall write memory on the edge that enters RESP, exactly once per request.
REQ-023 Load data shall be the memory contents at that same edge, held stable while in RESP.
REQ-024 In RESP, rsp_valid_o shall stay 1 and all response outputs shall stay stable until rsp_ready_i=1.
REQ-025 On the RESP edge where rsp_ready_i=1, the FSM shall go RESP->IDLE.
REQ-026 A new request shall not be accepted in the same cycle as a response handshake; the minimum request-to-request spacing is WAIT_STATES+2 cycles.
REQ-027 Any req_* change while the FSM is not in IDLE shall be ignored.

Reset
REQ-028 While reset=1, the FSM shall go to IDLE, the wait counter shall be 0, req_ready_o shall be 0, rsp_valid_o shall be 0, rsp_rdata_o shall be 0 and rsp_error_o shall be 0.
REQ-029 In the first cycle after reset deasserts, req_ready_o shall be 1.
REQ-030 Reset shall not clear memory contents.
REQ-031 Reset asserted during WAIT shall abort the request with no memory write.
REQ-032 Reset asserted during RESP shall drop the response.

Configuration
REQ-033 With DATA_MEMORY_RESPONDER_ERROR_CHECK_EN defined, a request with addr[1:0]!=0, addr<BASE_ADDR, or word index>=MEMORY_DEPTH shall complete with the normal latency and rsp_error_o=1, rsp_rdata_o=0, and no memory write.
REQ-034 Without the macro, addr[1:0] shall be ignored, the index shall wrap modulo MEMORY_DEPTH, and rsp_error_o shall be constant 0.

Structure
REQ-035 A shared package shall hold the FSM state encoding (2 bits), the response data width constant (32) and the default BASE_ADDR.
REQ-036 Storage shall be one sub-module, data_memory_responder_ram: a single-port synchronous RAM with write enable and MEMORY_DEPTH words.
REQ-037 The FSM, the wait counter and the address check shall live in the top module.

Verification
REQ-038 After reset, store 32'hDEAD_BEEF to 32'h1001_0004 with rsp_ready_i=1 -> rsp_valid_o at cycle 3 after accept, rsp_error_o=0; then load 32'h1001_0004 -> rsp_rdata_o=32'hDEAD_BEEF.
REQ-039 Load with rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable for all 5 cycles, req_ready_o=0 throughout, IDLE one cycle after rsp_ready_i=1.
REQ-040 With ERROR_CHECK_EN, store to 32'h1001_0002, then to 32'h1001_0400 (index 256) -> rsp_error_o=1 both times; reading index 0 afterwards returns the prior value unchanged.
REQ-041 Without ERROR_CHECK_EN, store 32'h1234_5678 to 32'h1001_0400 -> reading 32'h1001_0000 returns 32'h1234_5678.
REQ-042 With WAIT_STATES=0 -> rsp_valid_o one cycle after accept; back-to-back requests are accepted every 2 cycles.
REQ-043 Store accepted, then reset on the next cycle (WAIT state) -> outputs at reset values, and a later load of that address returns the old data.
